// File: rtl/vga_frame_buffer.sv
// Double-buffered, palette-indexed pixel source: look-ahead x/y/visible -> r/g/b in 3 clk.
// Display reads buffer `front`, drawing writes the other; swaps happen only on the frame sync pulse.
module vga_frame_buffer #(
  parameter int DEPTH    = 4,
  parameter int WIDTH    = 10,
  parameter int FB_W     = 160,
  parameter int FB_H     = 120,
  parameter int SHIFT    = 2,
  parameter int PIX_BITS = 4,
  parameter int AW       = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [WIDTH-1:0]      x,
  input  logic [WIDTH-1:0]      y,
  input  logic                  visible,
  input  logic                  sync,
  output logic [DEPTH-1:0]      r,
  output logic [DEPTH-1:0]      g,
  output logic [DEPTH-1:0]      b,
  input  logic                  wrEn,
  input  logic [AW-1:0]         wrAddr,
  input  logic [PIX_BITS-1:0]   wrData,
  input  logic                  palWrEn,
  input  logic [PIX_BITS-1:0]   palIdx,
  input  logic [3*DEPTH-1:0]    palColor,
  input  logic                  swapReq,
  output logic                  swapAck,
  output logic                  front
);

  localparam int              FB_SIZE   = FB_W * FB_H;
  localparam int              PAL_N     = 2 ** PIX_BITS;
  localparam logic [WIDTH-1:0] FB_W_X   = WIDTH'(FB_W);
  localparam logic [WIDTH-1:0] FB_H_Y   = WIDTH'(FB_H);
  localparam logic [AW-1:0]    FB_W_A   = AW'(FB_W);
  localparam logic [AW:0]      FB_SIZE_A = (AW + 1)'(FB_SIZE);

  logic [PIX_BITS-1:0] buf0 [FB_SIZE];
  logic [PIX_BITS-1:0] buf1 [FB_SIZE];
  logic [3*DEPTH-1:0]  pal  [PAL_N];

  logic [WIDTH-1:0]    fx, fy;
  logic [AW-1:0]       addr;
  logic                v0, v1;
  logic [PIX_BITS-1:0] rd0, rd1, idx;
  logic                sel;
  logic                pending;
  logic                wr_ok;

  assign fx    = x >> SHIFT;
  assign fy    = y >> SHIFT;
  assign wr_ok = wrEn && ({1'b0, wrAddr} < FB_SIZE_A);
  assign idx   = sel ? rd1 : rd0;

  // Each buffer gets its own read/write process so it maps onto one BRAM.
  always_ff @(posedge clk) begin
    if (wr_ok && front) buf0[wrAddr] <= wrData;
    rd0 <= buf0[addr];
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !front) buf1[wrAddr] <= wrData;
    rd1 <= buf1[addr];
  end

  // The product is truncated to AW bits; AW is sized to hold FB_W*FB_H.
  always_ff @(posedge clk) begin
    addr <= AW'(fy) * FB_W_A + AW'(fx);
    sel  <= front;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
      r  <= '0;
      g  <= '0;
      b  <= '0;
    end else begin
      v0 <= visible && (fx < FB_W_X) && (fy < FB_H_Y);
      v1 <= v0;
      {r, g, b} <= v1 ? pal[idx] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < PAL_N; i++) pal[i] <= {3{DEPTH'(i)}};
    end else if (palWrEn) begin
      pal[palIdx] <= palColor;
    end
  end

  // A request arriving with sync swaps immediately; repeated requests fold into one.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      front   <= 1'b0;
      pending <= 1'b0;
      swapAck <= 1'b0;
    end else begin
      swapAck <= 1'b0;
      if (sync && (pending || swapReq)) begin
        front   <= ~front;
        swapAck <= 1'b1;
        pending <= 1'b0;
      end else if (swapReq) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_buffer.sv
// Directed bench for vga_frame_buffer: reset, scaling, range limits, swap handshake, palette collision.
module tb_vga_frame_buffer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  x, y;
  logic        visible, sync;
  logic [3:0]  r, g, b;
  logic        wrEn;
  logic [14:0] wrAddr;
  logic [3:0]  wrData;
  logic        palWrEn;
  logic [3:0]  palIdx;
  logic [11:0] palColor;
  logic        swapReq, swapAck, front;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vga_frame_buffer dut (
    .clk(clk), .reset_n(reset_n), .x(x), .y(y), .visible(visible), .sync(sync),
    .r(r), .g(g), .b(b), .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
    .palWrEn(palWrEn), .palIdx(palIdx), .palColor(palColor),
    .swapReq(swapReq), .swapAck(swapAck), .front(front)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [14:0] a, input logic [3:0] d);
    wrAddr = a;
    wrData = d;
    wrEn   = 1'b1;
    step();
    wrEn   = 1'b0;
  endtask

  // Present one pixel, then sample the colour exactly 3 clk later.
  task automatic look(input string tag, input int px, input int py, input logic vis,
                      input logic [11:0] exp);
    x = 10'(px);
    y = 10'(py);
    visible = vis;
    repeat (3) step();
    chk(tag, {20'd0, r, g, b}, {20'd0, exp});
    visible = 1'b0;
  endtask

  task automatic pulse_sync();
    sync = 1'b1;
    step();
    sync = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; x = '0; y = '0; visible = 1'b0; sync = 1'b0;
    wrEn = 1'b0; wrAddr = '0; wrData = '0;
    palWrEn = 1'b0; palIdx = '0; palColor = '0; swapReq = 1'b0;

    repeat (3) step();
    chk("rst_rgb",   {20'd0, r, g, b}, 32'd0);
    chk("rst_ack",   {31'd0, swapAck}, 32'd0);
    chk("rst_front", {31'd0, front},   32'd0);
    reset_n = 1'b1;

    // Fill back buffer (buffer 1); the 19200 write is out of range.
    wr(15'd0, 4'd5);
    wr(15'd162, 4'd9);
    wr(15'd163, 4'd7);
    wr(15'd19199, 4'd11);
    wr(15'd19200, 4'd2);

    // Two requests before sync collapse into a single swap.
    swapReq = 1'b1; step(); swapReq = 1'b0;
    step();
    swapReq = 1'b1; step(); swapReq = 1'b0;
    chk("pend_no_ack", {31'd0, swapAck}, 32'd0);
    pulse_sync();
    chk("swap_ack",   {31'd0, swapAck}, 32'd1);
    chk("swap_front", {31'd0, front},   32'd1);
    step();
    chk("ack_pulse",  {31'd0, swapAck}, 32'd0);
    pulse_sync();
    chk("no_dbl_ack",   {31'd0, swapAck}, 32'd0);
    chk("no_dbl_front", {31'd0, front},   32'd1);

    // Exact 3-cycle latency on a single-cycle visible pixel.
    repeat (3) step();
    x = 10'd0; y = 10'd0; visible = 1'b1;
    step(); visible = 1'b0;
    chk("lat_c1", {20'd0, r, g, b}, 32'd0);
    step();
    chk("lat_c2", {20'd0, r, g, b}, 32'd0);
    step();
    chk("lat_c3", {20'd0, r, g, b}, 32'h555);
    step();
    chk("lat_c4", {20'd0, r, g, b}, 32'd0);

    look("scale_8_4",   8,   4,   1'b1, 12'h999);
    look("scale_11_7",  11,  7,   1'b1, 12'h999);
    look("scale_9_6",   9,   6,   1'b1, 12'h999);
    look("scale_12_4",  12,  4,   1'b1, 12'h777);
    look("invisible",   8,   4,   1'b0, 12'h000);
    look("corner",      639, 479, 1'b1, 12'hBBB);
    look("x_over",      640, 0,   1'b1, 12'h000);
    look("y_over",      0,   480, 1'b1, 12'h000);
    look("oor_wr_a0",   0,   0,   1'b1, 12'h555);

    // Back buffer is now buffer 0; seed it, then swap with request on the sync cycle.
    wr(15'd0, 4'd3);
    swapReq = 1'b1; sync = 1'b1;
    step();
    swapReq = 1'b0; sync = 1'b0;
    chk("coinc_ack",   {31'd0, swapAck}, 32'd1);
    chk("coinc_front", {31'd0, front},   32'd0);
    step();
    chk("coinc_ack_off", {31'd0, swapAck}, 32'd0);

    // Palette write lands in the same cycle S2 reads entry 3.
    x = 10'd0; y = 10'd0; visible = 1'b1;
    step(); step();
    palWrEn = 1'b1; palIdx = 4'd3; palColor = 12'hF00;
    step();
    palWrEn = 1'b0;
    chk("pal_old", {20'd0, r, g, b}, 32'h333);
    step();
    chk("pal_new", {20'd0, r, g, b}, 32'hF00);

    // A pending swap is dropped by reset.
    swapReq = 1'b1; step(); swapReq = 1'b0;
    reset_n = 1'b0;
    step();
    chk("rst_mid_rgb",   {20'd0, r, g, b}, 32'd0);
    chk("rst_mid_front", {31'd0, front},   32'd0);
    reset_n = 1'b1;
    visible = 1'b0;
    step();
    pulse_sync();
    chk("drop_ack",   {31'd0, swapAck}, 32'd0);
    chk("drop_front", {31'd0, front},   32'd0);
    look("pal_ramp_back", 0, 0, 1'b1, 12'h333);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_frame_buffer.md
# vga_frame_buffer

Double-buffered, palette-indexed pixel source that sits directly upstream of the VGA pixel controller. It turns the controller's look-ahead `x`/`y`/`visible` into `r`/`g`/`b` with a fixed 3-cycle latency, reading from a front buffer while drawing logic writes into a back buffer. Buffers swap on request, only at the controller's frame `sync` pulse, so the display never tears.

## Interface
Parameters:
- `DEPTH`, 4: bits per colour channel; matches the pixel controller.
- `WIDTH`, 10: width of `x`/`y`.
- `FB_W`, 160: framebuffer width in stored pixels.
- `FB_H`, 120: framebuffer height in stored pixels.
- `SHIFT`, 2: screen-to-framebuffer scale; each stored pixel covers 2^SHIFT × 2^SHIFT screen pixels.
- `PIX_BITS`, 4: palette index width; the palette has 2^PIX_BITS entries.
- `AW`, 15: framebuffer address width; must satisfy 2^AW ≥ FB_W*FB_H.

Ports:
- `clk`  in  1: system clock, 50.4 MHz, same clock as the pixel controller.
- `reset_n`  in  1: synchronous, active-low reset.
- `x`, `y`  in  WIDTH: look-ahead pixel position from the pixel controller.
- `visible`  in  1: `x`/`y` lie in the active area.
- `sync`  in  1: one-`clk` frame pulse from the pixel controller.
- `r`, `g`, `b`  out  DEPTH: registered pixel colour.
- `wrEn`  in  1: write the back buffer this cycle.
- `wrAddr`  in  AW: back-buffer address, `row*FB_W + col`.
- `wrData`  in  PIX_BITS: palette index to store.
- `palWrEn`  in  1: write one palette entry.
- `palIdx`  in  PIX_BITS: palette entry to write.
- `palColor`  in  3*DEPTH: {R,G,B} value for that entry.
- `swapReq`  in  1: request a buffer swap at the next frame boundary.
- `swapAck`  out  1: one-`clk` pulse when the swap takes effect.
- `front`  out  1: index of the buffer currently being displayed.

## Operation
- Two framebuffers, each FB_W*FB_H × PIX_BITS, in synchronous single-read BRAM.
  - Buffer `front` is read-only from the display side.
  - Buffer `~front` receives all writes.
  - Contents are not reset.
- Writes:
  - On `wrEn`, store `wrData` at `wrAddr` in the back buffer.
  - A `wrEn` with `wrAddr ≥ FB_W*FB_H` is ignored.
- Palette: 2^PIX_BITS registers of 3*DEPTH bits.
  - On reset, entry i = {i,i,i}, truncated or zero-extended to DEPTH; this is a grayscale ramp.
  - A `palWrEn` write takes effect the next cycle.
  - A lookup in the same cycle as a write to the same entry returns the old value.
- Read pipeline, one stage per `clk`:
  - S0: `fx = x>>SHIFT`, `fy = y>>SHIFT`. Register `addr = fy*FB_W + fx`. Register `v0 = visible && fx<FB_W && fy<FB_H`.
  - S1: BRAM read of `addr` from the front buffer. Register `v1 = v0`.
  - S2: `{r,g,b} <= v1 ? palette[index] : 0`.
- Multiply width: `fy*FB_W` is computed at AW bits; truncation is legal only because of the AW constraint above.
- Swap handshake:
  - State is the `pending` flag and `front`.
  - `swapReq` sets `pending`. A request while `pending` is already set is absorbed, with no double swap.
  - In a cycle with `sync` and (`pending` or `swapReq`): toggle `front`, pulse `swapAck` high for exactly that `clk`, clear `pending`.
  - `swapReq` coincident with `sync` swaps at that same `sync`.
- The buffer select for S1 is sampled from `front` in the S1 cycle. Pixels already in flight at a swap belong to the blanking interval, so no visible pixel mixes buffers.
- Reset mid-operation:
  - A pending swap is dropped.
  - `front` returns to 0.
  - The pipeline valids clear, so output is black from the next cycle.
  - Palette returns to the grayscale ramp.

## Timing
- Reset values: `r=g=b=0`, `swapAck=0`, `front=0`, `pending=0`, `v0=v1=0`.
- Latency from `x`/`y`/`visible` to `r`/`g`/`b` is exactly 3 `clk`.
  - This fits within one pixel-clock period (2 `clk`) plus one look-ahead pixel.
  - The pixel controller is instantiated with LATENCY=1.
- Throughput: one lookup per `clk`.
- The write port is fully independent of the read pipeline. A write to the front buffer is impossible by construction.
- `swapAck` rises in the cycle after the `sync` pulse. `front` shows its new value in that same cycle.

## Test plan
- Reset and default palette:
  - Stimulus: hold `reset_n=0` for 3 cycles, then drive `x=0`, `y=0`, `visible=1`.
  - Response: `r=g=b=0` during reset; `swapAck=0`; `front=0`.
  - Then, with the buffer preloaded at address 0 with index 5, `{r,g,b}={5,5,5}` exactly 3 cycles later.
- Scaling and addressing:
  - Stimulus: write index 9 at `wrAddr=1*160+2=162`, then swap.
  - Response: `x=8..11`, `y=4..7` all give palette[9]; `x=12`, `y=4` gives palette[index at 163].
- Out-of-range handling:
  - Stimulus: `visible=0`, then `x=639`, `y=479`, `visible=1`, then a `wrEn` with `wrAddr=19200`.
  - Response: black, then the colour at address 119*160+159; the out-of-range write changes no location.
- Swap handshake:
  - Stimulus: pulse `swapReq` twice before `sync`.
  - Response: exactly one `swapAck` at `sync`; `front` toggles once.
  - Stimulus: `swapReq` coincident with `sync`.
  - Response: swap at that `sync`.
  - Stimulus: `swapReq` followed by reset before `sync`.
  - Response: no swap.
- Palette write collision:
  - Stimulus: `palWrEn` on entry 3 with `palColor=12'hF00` in the same cycle S2 looks up entry 3.
  - Response: the old colour is output; the following lookup returns `r=F`, `g=0`, `b=0`.
